// File: rtl/imem_boot_ctrl_if.sv
// Program word stream into the instruction-memory boot loader.
// master = stream source, slave = loader.
interface imem_boot_ctrl_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot sequencer: stream load, sum-verify readback,
// then hand the memory read port to the core fetch PC.
module imem_boot_ctrl #(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AW:0]          load_len,
    imem_boot_ctrl_if.slave      s,
    input  logic [31:0]          core_pc_word,
    output logic                 core_run,
    output logic [31:0]          imem_addr_word,
    input  logic [31:0]          imem_instr,
    output logic                 imem_we,
    output logic [AW-1:0]        imem_waddr,
    output logic [31:0]          imem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [31:0]          checksum
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] VERIFY = 3'd2;
    localparam logic [2:0] RUN    = 3'd3;
    localparam logic [2:0] ERR    = 3'd4;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [2:0]  state;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] len_q;
    logic [31:0] vsum;

    logic        can_start;
    logic        len_ok;
    logic        last_wr;
    logic        last_rd;
    logic [31:0] vsum_nxt;

    assign can_start = start &&
        (state == IDLE || state == RUN || state == ERR);
    assign len_ok   = (load_len != '0) && (load_len <= DEPTH_W);
    assign last_wr  = (wr_ptr == len_q - 1'b1);
    assign last_rd  = (rd_ptr == len_q - 1'b1);
    assign vsum_nxt = vsum + imem_instr;

    // Writes are masked during reset so an in-flight beat is not committed.
    always_comb begin
        s.s_ready      = (state == LOAD) && !rst;
        imem_we        = s.s_ready && s.s_valid;
        imem_waddr     = wr_ptr[AW-1:0];
        imem_wdata     = s.s_data;
        busy           = (state == LOAD) || (state == VERIFY);
        done           = (state == RUN);
        core_run       = (state == RUN);
        error          = (state == ERR);
        imem_addr_word = '0;
        if (state == VERIFY)
            imem_addr_word = 32'(rd_ptr);
        else if (state == RUN)
            imem_addr_word = core_pc_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            len_q    <= '0;
            checksum <= '0;
            vsum     <= '0;
        end else begin
            unique case (state)
                IDLE, RUN, ERR: begin
                    if (can_start) begin
                        if (len_ok) begin
                            len_q    <= load_len;
                            wr_ptr   <= '0;
                            rd_ptr   <= '0;
                            checksum <= '0;
                            vsum     <= '0;
                            state    <= LOAD;
                        end else begin
                            state    <= ERR;
                        end
                    end
                end
                LOAD: begin
                    if (s.s_valid) begin
                        checksum <= checksum + s.s_data;
                        wr_ptr   <= wr_ptr + 1'b1;
                        if (last_wr)
                            state <= VERIFY;
                    end
                end
                VERIFY: begin
                    vsum   <= vsum_nxt;
                    rd_ptr <= rd_ptr + 1'b1;
                    if (last_rd)
                        state <= (vsum_nxt == checksum) ? RUN : ERR;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl with a write scoreboard and
// a behavioural instruction memory.
module tb_imem_boot_ctrl;

    localparam int DEPTH = 1024;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   load_len;
    logic [31:0]   core_pc_word;
    logic          core_run;
    logic [31:0]   imem_addr_word;
    logic [31:0]   imem_instr;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic          error;
    logic [31:0]   checksum;

    imem_boot_ctrl_if sif ();

    imem_boot_ctrl #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .load_len       (load_len),
        .s              (sif.slave),
        .core_pc_word   (core_pc_word),
        .core_run       (core_run),
        .imem_addr_word (imem_addr_word),
        .imem_instr     (imem_instr),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .checksum       (checksum)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:DEPTH-1];
    logic        corrupt;

    always @(posedge clk)
        if (imem_we) mem[imem_waddr] <= imem_wdata;

    always_comb
        imem_instr = mem[imem_addr_word[AW-1:0]] ^
            ((corrupt && busy && imem_addr_word == 32'd2) ?
             32'h0000_0100 : 32'h0);

    int          n_vec = 0;
    int          n_err = 0;
    int          wr_cnt = 0;
    int          wr_idx = 0;
    int          wr_base;
    logic [41:0] wq [$];
    logic [41:0] exp_w;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we) begin
            wr_cnt++;
            exp_w = (wq.size() != 0) ? wq.pop_front() : '1;
            chk("imem_write", 64'({imem_waddr, imem_wdata}), 64'(exp_w));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        start    = 1'b1;
        load_len = (AW+1)'(len);
        wr_idx   = 0;
        tick();
        start    = 1'b0;
    endtask

    task automatic send(input logic [31:0] w, input int gap);
        for (int g = 0; g < gap; g++) begin
            sif.s_valid = 1'b0;
            tick();
        end
        sif.s_valid = 1'b1;
        sif.s_data  = w;
        wq.push_back({10'(wr_idx), w});
        wr_idx++;
        tick();
        sif.s_valid = 1'b0;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 4000 && !(done || error); i++)
            tick();
        chk("wait_end", 64'(done | error), 64'd1);
    endtask

    task automatic load4(input int gap);
        do_start(4);
        send(32'h11, gap);
        send(32'h22, gap);
        send(32'h33, gap);
        send(32'h44, gap);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        load_len     = '0;
        core_pc_word = 32'd0;
        corrupt      = 1'b0;
        sif.s_valid  = 1'b0;
        sif.s_data   = 32'h0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_outs", 64'({core_run, busy, done, error, imem_we,
                             sif.s_ready}), 64'd0);
        chk("rst_addr", 64'(imem_addr_word), 64'd0);
        chk("rst_csum", 64'(checksum), 64'd0);

        // T1: back-to-back load, exact latency
        wr_base = wr_cnt;
        do_start(4);
        chk("t1_load", 64'({busy, sif.s_ready, core_run}), 64'b110);
        send(32'h11, 0);
        send(32'h22, 0);
        send(32'h33, 0);
        send(32'h44, 0);
        chk("t1_vfy0", 64'({busy, sif.s_ready}), 64'b10);
        chk("t1_va0", 64'(imem_addr_word), 64'd0);
        tick();
        chk("t1_va1", 64'(imem_addr_word), 64'd1);
        tick();
        tick();
        chk("t1_nodone", 64'({done, busy}), 64'b01);
        tick();
        chk("t1_run", 64'({done, core_run, busy, error}), 64'b1100);
        chk("t1_csum", 64'(checksum), 64'h0000_00AA);
        chk("t1_nwr", 64'(wr_cnt - wr_base), 64'd4);

        // T2: gapped stream
        wr_base = wr_cnt;
        load4(1);
        wait_end();
        chk("t2_run", 64'({done, core_run, error}), 64'b110);
        chk("t2_csum", 64'(checksum), 64'h0000_00AA);
        chk("t2_nwr", 64'(wr_cnt - wr_base), 64'd4);

        // T3: illegal lengths, then single-word recovery
        wr_base = wr_cnt;
        do_start(0);
        chk("t3_err0", 64'({error, core_run, done}), 64'b100);
        do_start(DEPTH + 1);
        chk("t3_errbig", 64'({error, core_run, busy}), 64'b100);
        chk("t3_nowr", 64'(wr_cnt - wr_base), 64'd0);
        do_start(1);
        send(32'hDEAD_BEEF, 0);
        wait_end();
        chk("t3_run", 64'({done, error}), 64'b10);
        chk("t3_csum", 64'(checksum), 64'hDEAD_BEEF);

        // T4: readback corruption at word 2
        corrupt = 1'b1;
        load4(0);
        wait_end();
        chk("t4_err", 64'({error, core_run, done}), 64'b100);
        chk("t4_addr", 64'(imem_addr_word), 64'd0);
        corrupt = 1'b0;

        // T5: checksum wrap and PC pass-through
        do_start(2);
        send(32'hFFFF_FFFF, 0);
        send(32'h0000_0002, 0);
        wait_end();
        chk("t5_run", 64'({done, error}), 64'b10);
        chk("t5_csum", 64'(checksum), 64'h0000_0001);
        core_pc_word = 32'd5;
        #1;
        chk("t5_pc5", 64'(imem_addr_word), 64'd5);
        core_pc_word = 32'h0000_0377;
        #1;
        chk("t5_pc377", 64'(imem_addr_word), 64'h377);

        // T6: reset mid-load, reload, restart from RUN
        do_start(4);
        send(32'h11, 0);
        send(32'h22, 0);
        rst         = 1'b1;
        sif.s_valid = 1'b1;
        sif.s_data  = 32'h5555_5555;
        #1;
        chk("t6_rstwe", 64'({imem_we, sif.s_ready}), 64'd0);
        tick();
        rst         = 1'b0;
        sif.s_valid = 1'b0;
        chk("t6_outs", 64'({core_run, busy, done, error, imem_we,
                            sif.s_ready}), 64'd0);
        chk("t6_addr", 64'(imem_addr_word), 64'd0);
        chk("t6_csum", 64'(checksum), 64'd0);
        load4(0);
        wait_end();
        chk("t6_run", 64'({done, error}), 64'b10);
        chk("t6_csum2", 64'(checksum), 64'h0000_00AA);
        do_start(2);
        chk("t6_restart", 64'({core_run, busy, sif.s_ready}), 64'b011);
        send(32'h1000_0000, 0);
        send(32'h0000_0003, 0);
        wait_end();
        chk("t6_run2", 64'({done, error}), 64'b10);
        chk("t6_csum3", 64'(checksum), 64'h1000_0003);

        tick();
        chk("sb_empty", 64'(wq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
